// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard control unit: FSM state type and pipeline constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hazard_pkg;

  // FSM state encoding; the numeric values are visible on state_o for debug.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } hz_state_e;

  // Register x0 is hardwired to zero, so it can never carry a load-use dependency.
  localparam logic [4:0] X0_REG = 5'd0;

  // pc_sel values: sequential PC+4 versus redirect target.
  localparam logic PC_SEL_SEQ   = 1'b0;
  localparam logic PC_SEL_REDIR = 1'b1;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard unit bundle: ID/EX hazard sources in, stage enables and redirect out.
// Latency: n/a (wires only).
// Backpressure: mem_busy travels here and freezes every stage enable.
interface hazard_control_unit_if #(
  parameter int XLEN = 32
) ();

  // Hazard sources observed in the pipeline.
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      ex_rd;
  logic            ex_memread;
  logic            ex_branch_taken;
  logic            ex_jal;
  logic            ex_jalr;
  logic [XLEN-1:0] ex_target;
  logic            mem_busy;

  // Controls returned to the pipeline.
  logic            pc_write;
  logic            if_id_write;
  logic            id_ex_write;
  logic            if_id_flush;
  logic            id_ex_bubble;
  logic            pc_sel;
  logic [XLEN-1:0] pc_target;
  logic [1:0]      state_o;

  // The pipeline side drives hazard sources and consumes controls.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, ex_jal, ex_jalr, ex_target, mem_busy,
    input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble,
           pc_sel, pc_target, state_o
  );

  // The hazard unit consumes hazard sources and drives controls.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, ex_jal, ex_jalr, ex_target, mem_busy,
    output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble,
           pc_sel, pc_target, state_o
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: EX load writes a register the ID instruction actually reads.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether the result is honoured.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // A source only matters when the instruction really reads it; x0 never forwards a value.
  always_comb begin
    rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o = ex_memread_i && (ex_rd_i != X0_REG) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: freeze on mem_busy, redirect/flush on EX control transfer, stall on load-use.
// Latency: controls are combinational from state and inputs; state advances one cycle later.
// Backpressure: mem_busy deasserts every stage enable. Optional counters: HAZARD_PERF_CNT_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     freeze_cnt
`endif
);

  // Reject parameter values that would make the datapath meaningless.
  if (XLEN < 2 || CNT_W < 1) begin : g_bad_param
    $error("hazard_control_unit: XLEN must be >= 2 and CNT_W >= 1");
  end

  hz_state_e       state_q;
  hz_state_e       state_d;
  logic            load_use;
  logic            redirect;
  logic            stall_ok;
  logic [XLEN-1:0] redir_target;

  hazard_detect u_detect (
    .id_rs1_i     (hz.id_rs1),
    .id_rs2_i     (hz.id_rs2),
    .id_use_rs1_i (hz.id_use_rs1),
    .id_use_rs2_i (hz.id_use_rs2),
    .ex_rd_i      (hz.ex_rd),
    .ex_memread_i (hz.ex_memread),
    .load_use_o   (load_use)
  );

  // Cause decode: redirect target aligns JALR, and load-use is meaningless while ID is being squashed.
  always_comb begin
    redirect     = hz.ex_branch_taken || hz.ex_jal || hz.ex_jalr;
    stall_ok     = load_use && (state_q != ST_FLUSH);
    redir_target = hz.ex_jalr ? {hz.ex_target[XLEN-1:1], 1'b0} : hz.ex_target;
  end

  // Next-state and control outputs; priority is reset > mem_busy > redirect > load-use.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.id_ex_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.pc_sel       = PC_SEL_SEQ;
    hz.pc_target    = '0;
    state_d         = ST_RUN;

    if (!rst_n) begin
      // Hold the front end and keep squashing until reset releases.
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (hz.mem_busy) begin
      // Whole pipeline holds; any redirect stays parked in EX until memory is ready.
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.id_ex_write = 1'b0;
      state_d        = ST_FREEZE;
    end else if (redirect) begin
      hz.pc_sel       = PC_SEL_REDIR;
      hz.pc_target    = redir_target;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
      state_d         = ST_FLUSH;
    end else if (stall_ok) begin
      // Hold PC and IF/ID, push a bubble into EX so the load can complete.
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end
  end

  // State register; reset discards any pending freeze or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_q;
  logic             stall_evt;
  logic             flush_evt;

  // Event qualifiers mirror the priority used by the control outputs.
  always_comb begin
    flush_evt = !hz.mem_busy && redirect;
    stall_evt = !hz.mem_busy && !redirect && stall_ok;
  end

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (hz.mem_busy && (freeze_cnt_q != '1)) begin
        freeze_cnt_q <= freeze_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: stimulus pushes expected controls, a negedge monitor compares.
// Latency: expectations apply to the same cycle the stimulus is driven.
// Backpressure: mem_busy freeze sequences are part of the stimulus; counters checked with HAZARD_PERF_CNT_EN.
module tb_hazard_control_unit;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        mr;
    logic        br;
    logic        jal;
    logic        jalr;
    logic [31:0] tgt;
    logic        busy;
    logic        rstn;
  } stim_t;

  typedef struct {
    string       tag;
    logic        pcw;
    logic        ifw;
    logic        idw;
    logic        fl;
    logic        bb;
    logic        sel;
    logic [31:0] tgt;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  hazard_control_unit_if #(.XLEN(32)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt;
  logic [TB_CNT_W-1:0] flush_cnt;
  logic [TB_CNT_W-1:0] freeze_cnt;
`endif

  hazard_control_unit #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hz         (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .freeze_cnt (freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic stim_t s_idle();
    stim_t s;
    s = '{rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, mr: 1'b0,
          br: 1'b0, jal: 1'b0, jalr: 1'b0, tgt: 32'd0, busy: 1'b0, rstn: 1'b1};
    return s;
  endfunction

  function automatic stim_t s_lu1(input logic [4:0] rd, input logic [4:0] rs1);
    stim_t s;
    s     = s_idle();
    s.mr  = 1'b1;
    s.rd  = rd;
    s.rs1 = rs1;
    s.u1  = 1'b1;
    return s;
  endfunction

  function automatic exp_t mk(input string tag, input logic pcw, input logic ifw, input logic idw,
                              input logic fl, input logic bb, input logic sel,
                              input logic [31:0] tgt, input hz_state_e st);
    exp_t e;
    e = '{tag: tag, pcw: pcw, ifw: ifw, idw: idw, fl: fl, bb: bb, sel: sel, tgt: tgt, st: st};
    return e;
  endfunction

  function automatic exp_t e_norm(input string tag, input hz_state_e st);
    return mk(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, st);
  endfunction
  function automatic exp_t e_stall(input string tag, input hz_state_e st);
    return mk(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, st);
  endfunction
  function automatic exp_t e_redir(input string tag, input logic [31:0] t, input hz_state_e st);
    return mk(tag, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, t, st);
  endfunction
  function automatic exp_t e_frz(input string tag, input hz_state_e st);
    return mk(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, st);
  endfunction
  function automatic exp_t e_rst(input string tag, input hz_state_e st);
    return mk(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, st);
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue what the DUT must show.
  task automatic apply(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst_n              = s.rstn;
    hz.id_rs1          = s.rs1;
    hz.id_rs2          = s.rs2;
    hz.id_use_rs1      = s.u1;
    hz.id_use_rs2      = s.u2;
    hz.ex_rd           = s.rd;
    hz.ex_memread      = s.mr;
    hz.ex_branch_taken = s.br;
    hz.ex_jal          = s.jal;
    hz.ex_jalr         = s.jalr;
    hz.ex_target       = s.tgt;
    hz.mem_busy        = s.busy;
    exp_q.push_back(e);
  endtask

  // Monitor: compare settled combinational outputs on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.tag, ".pc_write"},     {63'd0, hz.pc_write},     {63'd0, mon_e.pcw});
      chk({mon_e.tag, ".if_id_write"},  {63'd0, hz.if_id_write},  {63'd0, mon_e.ifw});
      chk({mon_e.tag, ".id_ex_write"},  {63'd0, hz.id_ex_write},  {63'd0, mon_e.idw});
      chk({mon_e.tag, ".if_id_flush"},  {63'd0, hz.if_id_flush},  {63'd0, mon_e.fl});
      chk({mon_e.tag, ".id_ex_bubble"}, {63'd0, hz.id_ex_bubble}, {63'd0, mon_e.bb});
      chk({mon_e.tag, ".pc_sel"},       {63'd0, hz.pc_sel},       {63'd0, mon_e.sel});
      chk({mon_e.tag, ".pc_target"},    {32'd0, hz.pc_target},    {32'd0, mon_e.tgt});
      chk({mon_e.tag, ".state"},        {62'd0, hz.state_o},      {62'd0, mon_e.st});
    end
  end

  initial begin
    stim_t s;
    int    waited;

    rst_n              = 1'b0;
    hz.id_rs1          = '0;
    hz.id_rs2          = '0;
    hz.id_use_rs1      = 1'b0;
    hz.id_use_rs2      = 1'b0;
    hz.ex_rd           = '0;
    hz.ex_memread      = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_jal          = 1'b0;
    hz.ex_jalr         = 1'b0;
    hz.ex_target       = '0;
    hz.mem_busy        = 1'b0;

    // Reset: forced outputs, state RUN.
    s = s_idle(); s.rstn = 1'b0;
    apply(s, e_rst("reset", ST_RUN));
    apply(s_idle(), e_norm("run_idle", ST_RUN));

    // Load-use on rs1, then normal flow.
    apply(s_lu1(5'd5, 5'd5), e_stall("lu_rs1", ST_RUN));
    apply(s_idle(), e_norm("lu_after", ST_RUN));

    // x0 destination never stalls.
    apply(s_lu1(5'd0, 5'd0), e_norm("lu_x0", ST_RUN));

    // Load-use through rs2; then rs2 match without use does not stall.
    s = s_idle(); s.mr = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
    apply(s, e_stall("lu_rs2", ST_RUN));
    s.u2 = 1'b0;
    apply(s, e_norm("rs2_unused", ST_RUN));

    // Non-load producer never stalls.
    s = s_lu1(5'd9, 5'd9); s.mr = 1'b0;
    apply(s, e_norm("no_memread", ST_RUN));

    // JALR clears bit 0 of the target, then FLUSH, then RUN.
    s = s_idle(); s.jalr = 1'b1; s.tgt = 32'h0000_1003;
    apply(s, e_redir("jalr", 32'h0000_1002, ST_RUN));
    apply(s_idle(), e_norm("jalr_flush", ST_FLUSH));
    apply(s_idle(), e_norm("jalr_run", ST_RUN));

    // Branch plus load-use: redirect wins, target unmodified.
    s = s_lu1(5'd5, 5'd5); s.br = 1'b1; s.tgt = 32'h0000_2001;
    apply(s, e_redir("br_and_lu", 32'h0000_2001, ST_RUN));
    // Load-use suppressed while in FLUSH.
    apply(s_lu1(5'd5, 5'd5), e_norm("lu_in_flush", ST_FLUSH));
    apply(s_idle(), e_norm("flush_run", ST_RUN));

    // mem_busy with JAL held: 3 freeze cycles, then the JAL fires.
    s = s_idle(); s.jal = 1'b1; s.tgt = 32'h0000_3000; s.busy = 1'b1;
    apply(s, e_frz("busy1", ST_RUN));
    apply(s, e_frz("busy2", ST_FREEZE));
    apply(s, e_frz("busy3", ST_FREEZE));
    s.busy = 1'b0;
    apply(s, e_redir("busy_release", 32'h0000_3000, ST_FREEZE));
    // New redirect while in FLUSH is honoured.
    s = s_idle(); s.jal = 1'b1; s.tgt = 32'h0000_4000;
    apply(s, e_redir("jal_in_flush", 32'h0000_4000, ST_FLUSH));
    apply(s_idle(), e_norm("flush_again", ST_FLUSH));
    apply(s_idle(), e_norm("back_run", ST_RUN));

    // Load-use acted on in the cycle a freeze ends.
    s = s_idle(); s.busy = 1'b1;
    apply(s, e_frz("busy_lu", ST_RUN));
    apply(s_lu1(5'd12, 5'd12), e_stall("lu_after_freeze", ST_FREEZE));
    apply(s_idle(), e_norm("lu_freeze_run", ST_RUN));

    // Reset during FREEZE with a redirect pending: forced outputs, then RUN with cause discarded.
    s = s_idle(); s.busy = 1'b1; s.jal = 1'b1; s.tgt = 32'h0000_5000;
    apply(s, e_frz("pre_rst1", ST_RUN));
    apply(s, e_frz("pre_rst2", ST_FREEZE));
    s.busy = 1'b0; s.rstn = 1'b0;
    apply(s, e_rst("rst_in_freeze", ST_FREEZE));
    apply(s_idle(), e_norm("post_rst", ST_RUN));

    // 20 consecutive stall cycles, two redirects, one busy cycle.
    for (int i = 0; i < 20; i++) begin
      apply(s_lu1(5'd3, 5'd3), e_stall("stall_run", ST_RUN));
    end
    s = s_idle(); s.br = 1'b1; s.tgt = 32'h0000_6000;
    apply(s, e_redir("cnt_br1", 32'h0000_6000, ST_RUN));
    apply(s, e_redir("cnt_br2", 32'h0000_6000, ST_FLUSH));
    s = s_idle(); s.busy = 1'b1;
    apply(s, e_frz("cnt_busy", ST_FLUSH));
    apply(s_idle(), e_norm("cnt_idle", ST_FREEZE));

`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_sat", {{(64-TB_CNT_W){1'b0}}, stall_cnt},  64'd15);
    chk("flush_cnt",     {{(64-TB_CNT_W){1'b0}}, flush_cnt},  64'd2);
    chk("freeze_cnt",    {{(64-TB_CNT_W){1'b0}}, freeze_cnt}, 64'd1);
`endif

    // Let the monitor drain the queue, bounded.
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/target width.
REQ-002 SHALL have parameter CNT_W, default 16: performance-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports id_rs1, id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs1, id_use_rs2, input, 1 each: the ID instruction reads that source.
REQ-007 SHALL have ports ex_rd (input, 5) and ex_memread (input, 1): destination register of the EX instruction, and EX holds a load.
REQ-008 SHALL have ports ex_branch_taken, ex_jal, ex_jalr, input, 1 each: EX-stage redirect causes.
REQ-009 SHALL have port ex_target, input, XLEN: redirect target computed from the immediate-generator output.
REQ-010 SHALL have port mem_busy, input, 1: data memory not ready; the whole pipeline must hold.
REQ-011 SHALL have ports pc_write, if_id_write, id_ex_write, output, 1 each: stage write enables.
REQ-012 SHALL have ports if_id_flush and id_ex_bubble, output, 1 each: squash IF/ID; insert NOP into ID/EX.
REQ-013 SHALL have ports pc_sel (output, 1) and pc_target (output, XLEN): select redirect target over PC+4.
REQ-014 SHALL have port state_o, output, 2: current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states RUN=0, FLUSH=1, FREEZE=2. Outputs are combinational from state and inputs; state is registered.
REQ-016 SHALL evaluate causes in fixed priority: mem_busy > redirect > load-use.
REQ-017 mem_busy=1 in any state SHALL drive pc_write=if_id_write=id_ex_write=0, with flush, bubble and pc_sel at 0; next state FREEZE.
REQ-018 In FREEZE with mem_busy=0, SHALL evaluate as RUN in that same cycle; a redirect held in EX during the freeze is acted on then.
REQ-019 Redirect SHALL be ex_branch_taken|ex_jal|ex_jalr. On redirect, the same cycle SHALL drive pc_sel=1, if_id_flush=1, id_ex_bubble=1, and pc_write=if_id_write=id_ex_write=1; next state FLUSH.
REQ-020 pc_target SHALL equal ex_target with bit 0 cleared when ex_jalr=1, and ex_target unmodified otherwise; it SHALL be 0 when pc_sel=0.
REQ-021 Load-use SHALL be ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-022 On load-use in RUN, SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1 and id_ex_write=1 for exactly one cycle; state stays RUN.
REQ-023 In FLUSH, load-use detection SHALL be suppressed because the ID instruction is squashed. A new redirect in FLUSH SHALL be honoured as in REQ-019. Otherwise next state is RUN.
REQ-024 In RUN with no cause, SHALL drive all write enables to 1 and flush, bubble and pc_sel to 0.

Reset
REQ-025 While rst_n=0 at a clock edge, state SHALL become RUN and counters SHALL become 0.
REQ-026 While rst_n=0, outputs SHALL be forced to pc_write=if_id_write=id_ex_write=0, if_id_flush=id_ex_bubble=1, pc_sel=0, pc_target=0. Reset mid-FREEZE or mid-FLUSH discards the pending cause.

Configuration
REQ-027 With HAZARD_PERF_CNT_EN defined, SHALL add outputs stall_cnt, flush_cnt and freeze_cnt (CNT_W each). Each counts cycles of load-use stall, redirect and mem_busy respectively, and saturates at all-ones.
REQ-028 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package hazard_pkg SHALL hold the state encoding typedef and the constants X0_REG=0 and PC_SEL_SEQ=0 / PC_SEL_REDIR=1.
REQ-030 Load-use comparison SHALL be a sub-module hazard_detect (combinational, 1-bit output), instantiated once.

Verification
REQ-031 Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then normal flow.
REQ-032 x0 guard: same stimulus as REQ-031 with ex_rd=0 -> no stall.
REQ-033 JALR: ex_jalr=1, ex_target=0x0000_1003 -> pc_sel=1, pc_target=0x0000_1002, flush=1 and bubble=1 for one cycle, then state FLUSH, then RUN.
REQ-034 Simultaneous events: redirect and load-use in the same cycle -> redirect response only. mem_busy plus redirect -> FREEZE for 3 cycles, then the redirect fires in the cycle mem_busy falls.
REQ-035 Reset: rst_n low for 1 cycle while in FREEZE -> state RUN, forced outputs as in REQ-026. With HAZARD_PERF_CNT_EN and CNT_W=4, 20 stall cycles -> stall_cnt=15.
